// File: rtl/gpio_pud_bist_pkg.sv
// rtl/gpio_pud_bist_pkg.sv - shared types and encodings for the pad pull-up/pull-down self-test
package gpio_pud_bist_pkg;

  // PDF/PUF encodings stay reserved when the force phases are compiled out
  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_SELECT  = 4'd1,
    S_PD_SET  = 4'd2,
    S_PD_CHK  = 4'd3,
    S_PDF_SET = 4'd4,
    S_PDF_CHK = 4'd5,
    S_PU_SET  = 4'd6,
    S_PU_CHK  = 4'd7,
    S_PUF_SET = 4'd8,
    S_PUF_CHK = 4'd9,
    S_RELEASE = 4'd10,
    S_DONE    = 4'd11
  } state_e;

  localparam logic [1:0] PUD_OFF = 2'b00;
  localparam logic [1:0] PUD_DN  = 2'b01;
  localparam logic [1:0] PUD_UP  = 2'b10;

  localparam logic [5:0] CODE_IDLE = 6'h30;
  localparam logic [5:0] CODE_PD   = 6'h31;
  localparam logic [5:0] CODE_PU   = 6'h32;
  localparam logic [5:0] CODE_DONE = 6'h3a;

endpackage

// File: rtl/gpio_pud_bist_sync.sv
// rtl/gpio_pud_bist_sync.sv - parametrised-width two-flop synchroniser for pad inputs
module gpio_pud_bist_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clock_i,
  input  logic             resetb_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/gpio_pud_bist.sv
// rtl/gpio_pud_bist.sv - GPIO pull-up/pull-down BIST sequencer
// Define GPIO_PUD_BIST_FORCE_EN to add the drive-against-pull (PDF/PUF) phases.
module gpio_pud_bist
  import gpio_pud_bist_pkg::*;
#(
  parameter int NCHAN    = 38,
  parameter int SETTLE_W = 8,
  parameter int CHAN_W   = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
  input  logic                clock_i,
  input  logic                resetb_i,
  input  logic                start_i,
  input  logic                abort_i,
  input  logic [NCHAN-1:0]    chan_mask_i,
  input  logic [SETTLE_W-1:0] settle_cycles_i,
  input  logic [NCHAN-1:0]    pad_in_i,
  output logic [2*NCHAN-1:0]  pull_sel_o,
  output logic [NCHAN-1:0]    ovr_en_o,
  output logic [NCHAN-1:0]    ovr_val_o,
  output logic                busy_o,
  output logic                done_o,
  output logic [NCHAN-1:0]    fail_map_o,
  output logic [CHAN_W-1:0]   cur_chan_o,
  output logic [5:0]          code_o
);

  localparam int PW = CHAN_W + 1;
  localparam int CW = SETTLE_W + 1;

  state_e              state_q, state_d;
  logic [NCHAN-1:0]    mask_q, mask_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [PW-1:0]       next_q, next_d;
  logic [CHAN_W-1:0]   cur_q, cur_d;
  logic [NCHAN-1:0]    fail_q, fail_d;

  logic [NCHAN-1:0]    pad_s;
  logic                found;
  logic [CHAN_W-1:0]   found_idx;
  logic                set_state, set_last, chk_state, chk_exp, busy;
  logic [1:0]          psel;
  logic                oe, ov;

  gpio_pud_bist_sync #(.WIDTH(NCHAN)) u_sync (
    .clock_i  (clock_i),
    .resetb_i (resetb_i),
    .d_i      (pad_in_i),
    .q_o      (pad_s)
  );

  // next_q holds scan pointer + 1, so 0 means "pointer at -1"
  always_comb begin
    found     = 1'b0;
    found_idx = '0;
    for (int i = NCHAN - 1; i >= 0; i--) begin
      if (mask_q[i] && (PW'(i) >= next_q)) begin
        found     = 1'b1;
        found_idx = CHAN_W'(i);
      end
    end
  end

  always_comb begin
    set_state = 1'b0;
    chk_state = 1'b0;
    chk_exp   = 1'b0;
    case (state_q)
      S_PD_SET, S_PU_SET, S_PDF_SET, S_PUF_SET: set_state = 1'b1;
      S_PD_CHK:  chk_state = 1'b1;
      S_PU_CHK:  begin chk_state = 1'b1; chk_exp = 1'b1; end
`ifdef GPIO_PUD_BIST_FORCE_EN
      S_PDF_CHK: begin chk_state = 1'b1; chk_exp = 1'b1; end
      S_PUF_CHK: chk_state = 1'b1;
`endif
      default: ;
    endcase
  end

  assign busy     = (state_q != S_IDLE) && (state_q != S_DONE);
  assign set_last = (cnt_q == ({1'b0, settle_q} + CW'(1)));

  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    settle_d = settle_q;
    next_d   = next_q;
    cur_d    = cur_q;
    fail_d   = fail_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i && !abort_i) begin
          fail_d   = '0;
          mask_d   = chan_mask_i;
          settle_d = settle_cycles_i;
          next_d   = '0;
          state_d  = S_SELECT;
        end
      end
      S_SELECT: begin
        if (found) begin
          cur_d   = found_idx;
          next_d  = PW'(found_idx) + PW'(1);
          state_d = S_PD_SET;
        end else begin
          state_d = S_DONE;
        end
      end
      S_PD_SET: if (set_last) state_d = S_PD_CHK;
      S_PD_CHK: begin
`ifdef GPIO_PUD_BIST_FORCE_EN
        state_d = S_PDF_SET;
`else
        state_d = S_PU_SET;
`endif
      end
`ifdef GPIO_PUD_BIST_FORCE_EN
      S_PDF_SET: if (set_last) state_d = S_PDF_CHK;
      S_PDF_CHK: state_d = S_PU_SET;
      S_PUF_SET: if (set_last) state_d = S_PUF_CHK;
      S_PUF_CHK: state_d = S_RELEASE;
`endif
      S_PU_SET: if (set_last) state_d = S_PU_CHK;
      S_PU_CHK: begin
`ifdef GPIO_PUD_BIST_FORCE_EN
        state_d = S_PUF_SET;
`else
        state_d = S_RELEASE;
`endif
      end
      S_RELEASE: state_d = S_SELECT;
      default:   state_d = S_IDLE;
    endcase

    if (chk_state && (pad_s[cur_q] != chk_exp)) fail_d[cur_q] = 1'b1;

    // abort keeps partial fail results but drops everything else
    if (abort_i && busy) begin
      state_d = S_IDLE;
      cur_d   = '0;
    end

    cnt_d = (set_state && (state_d == state_q)) ? cnt_q + CW'(1) : '0;
  end

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state_q  <= S_IDLE;
      mask_q   <= '0;
      settle_q <= '0;
      cnt_q    <= '0;
      next_q   <= '0;
      cur_q    <= '0;
      fail_q   <= '0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      settle_q <= settle_d;
      cnt_q    <= cnt_d;
      next_q   <= next_d;
      cur_q    <= cur_d;
      fail_q   <= fail_d;
    end
  end

  always_comb begin
    psel   = PUD_OFF;
    oe     = 1'b0;
    ov     = 1'b0;
    code_o = CODE_IDLE;
    case (state_q)
      S_PD_SET, S_PD_CHK: begin psel = PUD_DN; code_o = CODE_PD; end
      S_PU_SET, S_PU_CHK: begin psel = PUD_UP; code_o = CODE_PU; end
`ifdef GPIO_PUD_BIST_FORCE_EN
      S_PDF_SET, S_PDF_CHK: begin psel = PUD_DN; oe = 1'b1; ov = 1'b1; code_o = CODE_PD; end
      S_PUF_SET, S_PUF_CHK: begin psel = PUD_UP; oe = 1'b1; ov = 1'b0; code_o = CODE_PU; end
`endif
      S_DONE:  code_o = CODE_DONE;
      default: ;
    endcase
  end

  always_comb begin
    pull_sel_o = '0;
    ovr_en_o   = '0;
    ovr_val_o  = '0;
    for (int i = 0; i < NCHAN; i++) begin
      if (PW'(i) == {1'b0, cur_q}) begin
        pull_sel_o[2*i +: 2] = psel;
        ovr_en_o[i]          = oe;
        ovr_val_o[i]         = ov;
      end
    end
  end

  assign busy_o     = busy;
  assign done_o     = (state_q == S_DONE);
  assign fail_map_o = fail_q;
  assign cur_chan_o = cur_q;

endmodule

// File: tb/tb_gpio_pud_bist.sv
// tb/tb_gpio_pud_bist.sv - self-checking bench for gpio_pud_bist with resistive pad models
module tb_gpio_pud_bist;

`ifdef GPIO_PUD_BIST_FORCE_EN
  localparam int FORCE = 1;
`else
  localparam int FORCE = 0;
`endif
  localparam int LIMIT = 2000;

  logic        clock, resetb, start, abort;
  logic [7:0]  chan_mask, settle_cycles, pad_in;
  logic [15:0] pull_sel;
  logic [7:0]  ovr_en, ovr_val, fail_map;
  logic        busy, done;
  logic [2:0]  cur_chan;
  logic [5:0]  code;
  logic [7:0]  stuck_en, stuck_val;

  typedef struct {
    int         lat;
    logic [7:0] fmap;
    bit         ovr;
  } exp_t;

  exp_t       exp_q[$];
  logic [2:0] ch_q[$];
  int         checks, errors;

  gpio_pud_bist #(.NCHAN(8), .SETTLE_W(8)) dut (
    .clock_i         (clock),
    .resetb_i        (resetb),
    .start_i         (start),
    .abort_i         (abort),
    .chan_mask_i     (chan_mask),
    .settle_cycles_i (settle_cycles),
    .pad_in_i        (pad_in),
    .pull_sel_o      (pull_sel),
    .ovr_en_o        (ovr_en),
    .ovr_val_o       (ovr_val),
    .busy_o          (busy),
    .done_o          (done),
    .fail_map_o      (fail_map),
    .cur_chan_o      (cur_chan),
    .code_o          (code)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // strong drive beats a weak pull; an undriven, unpulled pad reads 0
  always_comb begin
    pad_in = '0;
    for (int i = 0; i < 8; i++) begin
      if (stuck_en[i])     pad_in[i] = stuck_val[i];
      else if (ovr_en[i])  pad_in[i] = ovr_val[i];
      else                 pad_in[i] = (pull_sel[2*i +: 2] == 2'b10);
    end
  end

  function automatic int cpc(input int s);
    return (FORCE != 0) ? 4 * (s + 3) + 2 : 2 * (s + 3) + 2;
  endfunction

  task automatic check_idle_outputs(input string name, input logic [7:0] exp_fail);
    checks++; if (pull_sel !== 16'h0) begin errors++; $display("FAIL %s_pull_sel actual=%h required=0000", name, pull_sel); end
    checks++; if (ovr_en !== 8'h0) begin errors++; $display("FAIL %s_ovr_en actual=%h required=00", name, ovr_en); end
    checks++; if (ovr_val !== 8'h0) begin errors++; $display("FAIL %s_ovr_val actual=%h required=00", name, ovr_val); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s_busy actual=%b required=0", name, busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL %s_done actual=%b required=0", name, done); end
    checks++; if (cur_chan !== 3'd0) begin errors++; $display("FAIL %s_cur_chan actual=%0d required=0", name, cur_chan); end
    checks++; if (code !== 6'h30) begin errors++; $display("FAIL %s_code actual=%h required=30", name, code); end
    checks++; if (fail_map !== exp_fail) begin errors++; $display("FAIL %s_fail_map actual=%h required=%h", name, fail_map, exp_fail); end
  endtask

  task automatic run_scan(input string name, input logic [7:0] m, input logic [7:0] s, input int mid_start);
    exp_t       ex;
    int         e, k;
    logic [5:0] prev;
    logic [2:0] ec;
    bit         bad, oseen;
    k = 0;
    for (int i = 0; i < 8; i++) if (m[i]) begin ch_q.push_back(3'(i)); k++; end
    ex.lat  = 1 + k * cpc(int'(s));
    ex.fmap = m & stuck_en;
    ex.ovr  = (FORCE != 0) && (k > 0);
    exp_q.push_back(ex);

    @(negedge clock);
    chan_mask = m; settle_cycles = s; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chan_mask = ~m; settle_cycles = s + 8'd3;
    e = 0; prev = code; bad = 0; oseen = 0;
    while (done !== 1'b1 && e < LIMIT) begin
      @(posedge clock); e++;
      @(negedge clock);
      start = (mid_start != 0) && (e == mid_start);
      if (code == 6'h31 && prev == 6'h30) begin
        checks++;
        if (ch_q.size() == 0) begin
          errors++; $display("FAIL %s_chan_extra actual=%0d required=none", name, cur_chan);
        end else begin
          ec = ch_q.pop_front();
          if (cur_chan !== ec) begin errors++; $display("FAIL %s_chan_order actual=%0d required=%0d", name, cur_chan, ec); end
        end
      end
      prev = code;
      for (int i = 0; i < 8; i++)
        if (!m[i] && (pull_sel[2*i +: 2] != 2'b00 || ovr_en[i])) bad = 1;
      if (ovr_en != 8'h0) oseen = 1;
    end
    start = 1'b0;

    ex = exp_q.pop_front();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL %s_done_timeout actual=%b required=1", name, done); end
    checks++; if (e != ex.lat) begin errors++; $display("FAIL %s_latency actual=%0d required=%0d", name, e, ex.lat); end
    checks++; if (fail_map !== ex.fmap) begin errors++; $display("FAIL %s_fail_map actual=%h required=%h", name, fail_map, ex.fmap); end
    checks++; if (code !== 6'h3a) begin errors++; $display("FAIL %s_code actual=%h required=3a", name, code); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s_busy actual=%b required=0", name, busy); end
    checks++; if (ch_q.size() != 0) begin errors++; $display("FAIL %s_chan_missing actual=%0d required=0", name, ch_q.size()); end
    ch_q.delete();
    checks++; if (bad) begin errors++; $display("FAIL %s_masked_driven actual=1 required=0", name); end
    checks++; if (oseen != ex.ovr) begin errors++; $display("FAIL %s_ovr_seen actual=%0d required=%0d", name, oseen, ex.ovr); end
  endtask

  task automatic test_reset();
    resetb = 1'b0; start = 1'b0; abort = 1'b0;
    chan_mask = 8'h0; settle_cycles = 8'd4; stuck_en = 8'h0; stuck_val = 8'h0;
    repeat (3) @(negedge clock);
    resetb = 1'b1;
    @(negedge clock);
    check_idle_outputs("reset", 8'h00);
  endtask

  task automatic test_all_good();
    run_scan("all_good", 8'hFF, 8'd4, 0);
  endtask

  task automatic test_stuck();
    stuck_en = 8'h08; stuck_val = 8'h08;
    run_scan("stuck3", 8'hFF, 8'd4, 20);
    stuck_en = 8'h00; stuck_val = 8'h00;
  endtask

  task automatic test_mask();
    stuck_en = 8'h20; stuck_val = 8'h20;
    run_scan("mask05", 8'h05, 8'd4, 0);
    stuck_en = 8'h00; stuck_val = 8'h00;
    run_scan("mask00", 8'h00, 8'd4, 0);
  endtask

  task automatic test_back_to_back();
    run_scan("b2b_a", 8'h81, 8'd2, 0);
    run_scan("b2b_b", 8'h7E, 8'd1, 0);
  endtask

  task automatic test_abort();
    int e;
    stuck_en = 8'h01; stuck_val = 8'h01;
    @(negedge clock);
    chan_mask = 8'hFF; settle_cycles = 8'd4; start = 1'b1;
    @(negedge clock);
    start = 1'b0; e = 0;
    while (!(code == 6'h32 && cur_chan == 3'd1) && e < LIMIT) begin
      @(posedge clock); e++;
      @(negedge clock);
    end
    checks++; if (e >= LIMIT) begin errors++; $display("FAIL abort_reach_pu_set actual=timeout required=reached"); end
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    check_idle_outputs("abort", 8'h01);
    abort = 1'b1; start = 1'b1;
    @(negedge clock);
    abort = 1'b0; start = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_start_busy actual=%b required=0", busy); end
    checks++; if (code !== 6'h30) begin errors++; $display("FAIL abort_start_code actual=%h required=30", code); end
    stuck_en = 8'h00; stuck_val = 8'h00;
  endtask

  task automatic test_reset_mid();
    int e;
    stuck_en = 8'h04; stuck_val = 8'h04;
    @(negedge clock);
    chan_mask = 8'hFF; settle_cycles = 8'd4; start = 1'b1;
    @(negedge clock);
    start = 1'b0; e = 0;
    while (!(code == 6'h31 && cur_chan == 3'd2 && ((FORCE == 0) || ovr_en != 8'h0)) && e < LIMIT) begin
      @(posedge clock); e++;
      @(negedge clock);
    end
    checks++; if (e >= LIMIT) begin errors++; $display("FAIL rstmid_reach_phase actual=timeout required=reached"); end
    #2 resetb = 1'b0;
    #1 check_idle_outputs("rstmid", 8'h00);
    @(negedge clock);
    resetb = 1'b1;
    stuck_en = 8'h00; stuck_val = 8'h00;
    run_scan("after_reset", 8'hFF, 8'd4, 0);
  endtask

  task automatic test_settle0();
    run_scan("settle0", 8'hFF, 8'd0, 0);
  endtask

  initial begin
    checks = 0; errors = 0;
    test_reset();
    test_all_good();
    test_stuck();
    test_mask();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    test_settle0();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
